// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/value request and BCD result bundle for bin2bcd_seq
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
);
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                overflow;
    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with sticky overflow for values >= 10^DIGITS and optional leading-zero blanking.
module bin2bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int BLANK  = 0
) (
    input logic          clk,
    input logic          rst,
    bin2bcd_seq_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, CONV} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]    work_q, work_d, adj, next_w, blanked, bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, done_q, done_d, carry_w, lead;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign adj[4*g+:4] = work_q[4*g+:4] >= 4'd5 ? work_q[4*g+:4] + 4'd3 : work_q[4*g+:4];
    end
    // the bit leaving the top digit is a carry into digit DIGITS, i.e. overflow
    assign next_w  = {adj[BW-2:0], bin_q[WIDTH-1]};
    assign carry_w = carry_q | adj[BW-1];

    always_comb begin
        blanked = next_w;
        lead    = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead = lead && (next_w[4*i+:4] == 4'd0);
            if (BLANK != 0 && lead) blanked[4*i+:4] = 4'hF;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (bus.start) begin
                bin_d   = bus.bin;
                work_d  = '0;
                carry_d = 1'b0;
                cnt_d   = CW'(WIDTH);
                state_d = CONV;
            end
        end else begin
            bin_d   = bin_q << 1;
            work_d  = next_w;
            carry_d = carry_w;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                bcd_d   = blanked;
                ovf_d   = carry_w;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = state_q == CONV;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: three configurations checked every cycle against an arithmetic model,
// plus directed vectors with hand-computed results.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start [3];
    logic [31:0] bin   [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        ovf_w  [3];
    logic [39:0] bcd_w  [3];
    int          ndone  [3];
    int          checks = 0;
    int          errors = 0;
    int          n, nd;

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pow10(int d);
        logic [63:0] p = 64'd1;
        for (int i = 0; i < d; i++) p = p * 64'd10;
        return p;
    endfunction

    function automatic logic [63:0] to_bcd(logic [63:0] v, int d, bit b);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i+:4] = 4'(v % 64'd10);
            v = v / 64'd10;
        end
        if (b)
            for (int i = d - 1; i > 0; i--) begin
                if (r[4*i+:4] != 4'd0) break;
                r[4*i+:4] = 4'hF;
            end
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = (g == 2) ? 16 : 32;
        localparam int D = (g == 0) ? 10 : (g == 1) ? 8 : 5;
        localparam int B = (g == 2) ? 1 : 0;
        bin2bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();
        assign bus.start = start[g];
        assign bus.bin   = bin[g][W-1:0];
        assign busy_w[g] = bus.busy;
        assign done_w[g] = bus.done;
        assign ovf_w[g]  = bus.overflow;
        assign bcd_w[g]  = 40'(bus.bcd);
        bin2bcd_seq #(.WIDTH(W), .DIGITS(D), .BLANK(B)) dut (.clk(clk), .rst(rst), .bus(bus));

        logic        m_busy, m_done, m_ovf;
        logic [63:0] m_bcd, m_val;
        int          m_cnt;
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
                m_ovf  <= 1'b0;
                m_bcd  <= '0;
                m_cnt  <= 0;
            end else begin
                m_done <= 1'b0;
                if (!m_busy) begin
                    if (start[g]) begin
                        m_busy <= 1'b1;
                        m_cnt  <= W;
                        m_val  <= 64'(bin[g][W-1:0]);
                    end
                end else if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_ovf  <= m_val >= pow10(D);
                    m_bcd  <= to_bcd(m_val % pow10(D), D, B != 0);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end

        always @(negedge clk) begin
            chk($sformatf("u%0d.busy", g), 64'(busy_w[g]), 64'(m_busy));
            chk($sformatf("u%0d.done", g), 64'(done_w[g]), 64'(m_done));
            chk($sformatf("u%0d.overflow", g), 64'(ovf_w[g]), 64'(m_ovf));
            chk($sformatf("u%0d.bcd", g), 64'(bcd_w[g]), m_bcd);
            if (done_w[g] === 1'b1) ndone[g]++;
        end
    end

    task automatic wait_done(int g, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done_w[g] !== 1'b1 && cyc < 200);
    endtask

    task automatic run(int g, logic [31:0] v, logic [39:0] eb, logic eo, string name);
        int c;
        @(negedge clk);
        start[g] = 1'b1;
        bin[g]   = v;
        @(negedge clk);
        start[g] = 1'b0;
        wait_done(g, c);
        chk({name, ".latency"}, 64'(c), (g == 2) ? 64'd16 : 64'd32);
        chk({name, ".bcd"}, 64'(bcd_w[g]), 64'(eb));
        chk({name, ".overflow"}, 64'(ovf_w[g]), 64'(eo));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            bin[i]   = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset%0d.bcd", i), 64'(bcd_w[i]), 64'h0);
            chk($sformatf("reset%0d.busy", i), 64'(busy_w[i]), 64'h0);
        end
        rst = 1'b0;

        run(0, 32'hFFFF_FFFF, 40'h42_9496_7295, 1'b0, "full");
        run(0, 32'd0, 40'h0, 1'b0, "zero");
        run(1, 32'd123456789, 40'h23_456789, 1'b1, "trunc");
        run(1, 32'd99999999, 40'h99_999999, 1'b0, "fit8");
        run(2, 32'd305, 40'hF_F305, 1'b0, "blank305");
        run(2, 32'd0, 40'hF_FFF0, 1'b0, "blank0");
        run(2, 32'd65535, 40'h6_5535, 1'b0, "blankmax");

        // second start mid-conversion must not disturb the first request
        @(negedge clk);
        start[0] = 1'b1;
        bin[0]   = 32'd1234;
        @(negedge clk);
        start[0] = 1'b0;
        nd = ndone[0];
        repeat (4) @(negedge clk);
        start[0] = 1'b1;
        bin[0]   = 32'd9999;
        @(negedge clk);
        start[0] = 1'b0;
        bin[0]   = 32'd0;
        wait_done(0, n);
        chk("repulse.bcd", 64'(bcd_w[0]), 64'h1234);
        repeat (40) @(negedge clk);
        chk("repulse.ndone", 64'(ndone[0] - nd), 64'd1);

        @(negedge clk);
        start[0] = 1'b1;
        bin[0]   = 32'd42;
        @(negedge clk);
        wait_done(0, n);
        chk("held.first", 64'(n), 64'd32);
        for (int k = 0; k < 2; k++) begin
            wait_done(0, n);
            chk($sformatf("held.interval%0d", k), 64'(n), 64'd33);
            chk($sformatf("held.bcd%0d", k), 64'(bcd_w[0]), 64'h42);
        end
        start[0] = 1'b0;

        @(negedge clk);
        start[0] = 1'b1;
        bin[0]   = 32'd555;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.busy", 64'(busy_w[0]), 64'h0);
        chk("arst.done", 64'(done_w[0]), 64'h0);
        chk("arst.overflow", 64'(ovf_w[0]), 64'h0);
        chk("arst.bcd", 64'(bcd_w[0]), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = ndone[0];
        repeat (40) @(negedge clk);
        chk("arst.nodone", 64'(ndone[0] - nd), 64'd0);
        chk("arst.hold", 64'(bcd_w[0]), 64'h0);
        run(0, 32'd7, 40'h7, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
